// File: rtl/multirate_enable_scheduler.sv
// Sample-rate / decimated-rate enable generator with an IDLE/PRIME/RUN sequencer that
// holds out_valid low until the filter chain has seen PRIME_SAMPLES strobes.
module multirate_enable_scheduler #(
   parameter int SYS_DIV       = 8,
   parameter int DEC           = 4,
   parameter int PRIME_SAMPLES = 16
) (
   input  logic                    i_clk,
   input  logic                    i_reset,
   input  logic                    i_run,
   input  logic                    i_resync,
   input  logic [7:0]              i_div_cfg,
   input  logic                    i_cfg_load,
   output logic                    o_cfg_ack,
   output logic                    o_sam_clk_en,
   output logic                    o_sym_clk_en,
   output logic [$clog2(DEC)-1:0]  o_phase,
   output logic                    o_out_valid,
   output logic [1:0]              o_state
);

   localparam int PHW = $clog2(DEC);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_RUN   = 2'd2
   } state_t;

   state_t           r_state, w_state_nxt;
   logic [7:0]       r_cnt, w_cnt_nxt;
   logic [7:0]       r_period, w_period_nxt;
   logic [PHW-1:0]   r_ph_cnt, w_ph_cnt_nxt;
   logic [7:0]       r_prime_cnt, w_prime_nxt;
   logic             r_pend, w_pend_nxt;
   logic [7:0]       r_pend_val, w_pend_val_nxt;
   logic             r_ack_dly, w_ack_dly_nxt;
   logic             r_cfg_ack, w_ack_nxt;
   logic             r_sam, w_sam_nxt;
   logic             r_sym, w_sym_nxt;
   logic [PHW-1:0]   r_phase, w_phase_nxt;
   logic             r_valid, w_valid_nxt;
   logic             w_strobe;
   logic             w_wrap;

   assign w_strobe = (r_cnt == r_period);
   assign w_wrap   = (r_ph_cnt == PHW'(DEC - 1));

   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_period_nxt   = r_period;
      w_ph_cnt_nxt   = r_ph_cnt;
      w_prime_nxt    = r_prime_cnt;
      w_pend_nxt     = r_pend;
      w_pend_val_nxt = r_pend_val;
      w_ack_dly_nxt  = 1'b0;
      w_ack_nxt      = r_ack_dly;
      w_sam_nxt      = 1'b0;
      w_sym_nxt      = 1'b0;
      w_phase_nxt    = r_phase;
      case (r_state)
         S_IDLE: begin
            w_cnt_nxt    = '0;
            w_ph_cnt_nxt = '0;
            w_prime_nxt  = '0;
            w_phase_nxt  = '0;
            if (i_cfg_load) begin
               w_period_nxt = i_div_cfg;
               w_ack_nxt    = 1'b1;
            end
            if (i_run) w_state_nxt = S_PRIME;
         end
         S_PRIME, S_RUN: begin
            if (!i_run) begin
               // Stopping flushes any pending period straight into the divider.
               w_state_nxt  = S_IDLE;
               w_cnt_nxt    = '0;
               w_ph_cnt_nxt = '0;
               w_prime_nxt  = '0;
               w_phase_nxt  = '0;
               w_pend_nxt   = 1'b0;
               if (i_cfg_load) begin
                  w_period_nxt = i_div_cfg;
                  w_ack_nxt    = 1'b1;
               end else if (r_pend) begin
                  w_period_nxt = r_pend_val;
                  w_ack_nxt    = 1'b1;
               end
            end else if (i_resync) begin
               w_state_nxt  = S_PRIME;
               w_cnt_nxt    = '0;
               w_ph_cnt_nxt = '0;
               w_prime_nxt  = '0;
               w_phase_nxt  = '0;
               if (i_cfg_load) begin
                  w_pend_nxt     = 1'b1;
                  w_pend_val_nxt = i_div_cfg;
               end
            end else begin
               if (i_cfg_load) begin
                  w_pend_nxt     = 1'b1;
                  w_pend_val_nxt = i_div_cfg;
               end
               if (w_strobe) begin
                  w_cnt_nxt    = '0;
                  w_sam_nxt    = 1'b1;
                  w_sym_nxt    = w_wrap;
                  w_phase_nxt  = r_ph_cnt;
                  w_ph_cnt_nxt = r_ph_cnt + PHW'(1);
                  // A pending period only takes effect on a symbol boundary, where phase is 0.
                  if (w_wrap && r_pend) begin
                     w_period_nxt  = r_pend_val;
                     w_state_nxt   = S_PRIME;
                     w_prime_nxt   = '0;
                     w_ack_dly_nxt = 1'b1;
                     w_pend_nxt    = i_cfg_load;
                  end else if (r_state == S_PRIME) begin
                     if (r_prime_cnt == 8'(PRIME_SAMPLES - 1)) begin
                        w_state_nxt = S_RUN;
                        w_prime_nxt = '0;
                     end else begin
                        w_prime_nxt = r_prime_cnt + 8'd1;
                     end
                  end
               end else begin
                  w_cnt_nxt = r_cnt + 8'd1;
               end
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
      w_valid_nxt = (w_state_nxt == S_RUN);
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_period    <= 8'(SYS_DIV - 1);
         r_ph_cnt    <= '0;
         r_prime_cnt <= '0;
         r_pend      <= 1'b0;
         r_pend_val  <= '0;
         r_ack_dly   <= 1'b0;
         r_cfg_ack   <= 1'b0;
         r_sam       <= 1'b0;
         r_sym       <= 1'b0;
         r_phase     <= '0;
         r_valid     <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_cnt       <= w_cnt_nxt;
         r_period    <= w_period_nxt;
         r_ph_cnt    <= w_ph_cnt_nxt;
         r_prime_cnt <= w_prime_nxt;
         r_pend      <= w_pend_nxt;
         r_pend_val  <= w_pend_val_nxt;
         r_ack_dly   <= w_ack_dly_nxt;
         r_cfg_ack   <= w_ack_nxt;
         r_sam       <= w_sam_nxt;
         r_sym       <= w_sym_nxt;
         r_phase     <= w_phase_nxt;
         r_valid     <= w_valid_nxt;
      end
   end

   assign o_cfg_ack    = r_cfg_ack;
   assign o_sam_clk_en = r_sam;
   assign o_sym_clk_en = r_sym;
   assign o_phase      = r_phase;
   assign o_out_valid  = r_valid;
   assign o_state      = r_state;

endmodule

// File: tb/tb_multirate_enable_scheduler.sv
// Bench for multirate_enable_scheduler: directed test-plan sequences, a table of divider
// settings, and randomized traffic compared every cycle against a modulo-arithmetic model.
module tb_multirate_enable_scheduler;

   localparam int SYS_DIV       = 8;
   localparam int DEC           = 4;
   localparam int PRIME_SAMPLES = 16;
   localparam int PHW           = $clog2(DEC);
   localparam int W             = 6 + PHW;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            run, resync, cfg_load;
   logic [7:0]      div_cfg;
   logic            o_cfg_ack, o_sam, o_sym, o_valid;
   logic [PHW-1:0]  o_phase;
   logic [1:0]      o_state;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] exp_q[$];

   // reference model state
   bit m_active, m_valid, m_pend, m_ack_delay;
   int m_t, m_k, m_primed, m_period, m_pend_val;

   typedef struct {
      logic [7:0] div_cfg;
      int         exp_first;
      int         exp_gap;
      int         exp_sym_first;
      int         exp_sym_gap;
   } vec_t;
   vec_t vecs[6];

   multirate_enable_scheduler #(
      .SYS_DIV(SYS_DIV), .DEC(DEC), .PRIME_SAMPLES(PRIME_SAMPLES)
   ) dut (
      .i_clk(clk), .i_reset(rst_n), .i_run(run), .i_resync(resync),
      .i_div_cfg(div_cfg), .i_cfg_load(cfg_load), .o_cfg_ack(o_cfg_ack),
      .o_sam_clk_en(o_sam), .o_sym_clk_en(o_sym), .o_phase(o_phase),
      .o_out_valid(o_valid), .o_state(o_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Strobe n lands where the time since alignment is a multiple of the period.
   task automatic model_step();
      bit e_ack, e_sam, e_sym, old_pend;
      int e_phase, e_state, old_val;
      e_ack = 0; e_sam = 0; e_sym = 0; e_phase = 0;
      if (!rst_n) begin
         m_active = 0; m_valid = 0; m_pend = 0; m_ack_delay = 0;
         m_period = SYS_DIV; m_t = 0; m_k = 0; m_primed = 0;
      end else begin
         e_ack = m_ack_delay;
         m_ack_delay = 0;
         if (!m_active) begin
            if (cfg_load) begin m_period = int'(div_cfg) + 1; e_ack = 1; end
            if (run) begin m_active = 1; m_t = 0; m_k = 0; m_primed = 0; m_valid = 0; end
         end else if (!run) begin
            m_active = 0; m_valid = 0;
            if (cfg_load) begin m_period = int'(div_cfg) + 1; e_ack = 1; end
            else if (m_pend) begin m_period = m_pend_val + 1; e_ack = 1; end
            m_pend = 0;
         end else if (resync) begin
            m_t = 0; m_k = 0; m_primed = 0; m_valid = 0;
            if (cfg_load) begin m_pend = 1; m_pend_val = int'(div_cfg); end
         end else begin
            old_pend = m_pend;
            old_val  = m_pend_val;
            if (cfg_load) begin m_pend = 1; m_pend_val = int'(div_cfg); end
            m_t++;
            if (m_t % m_period == 0) begin
               e_sam   = 1;
               e_phase = m_k % DEC;
               e_sym   = (e_phase == DEC - 1);
               m_k++;
               if (e_sym && old_pend) begin
                  m_period = old_val + 1; m_t = 0; m_k = 0; m_primed = 0;
                  m_valid = 0; m_ack_delay = 1; m_pend = cfg_load;
               end else if (!m_valid) begin
                  m_primed++;
                  if (m_primed >= PRIME_SAMPLES) m_valid = 1;
               end
            end
         end
      end
      e_state = !m_active ? 0 : (m_valid ? 2 : 1);
      exp_q.push_back({e_ack, e_sam, e_sym, PHW'(e_phase), m_valid, 2'(e_state)});
   endtask

   initial forever begin
      @(posedge clk);
      model_step();
   end

   // scoreboard: outputs are sampled on the falling edge
   initial forever begin
      logic [W-1:0] exp, act, mask;
      @(negedge clk);
      if (exp_q.size() > 0) begin
         exp  = exp_q.pop_front();
         act  = {o_cfg_ack, o_sam, o_sym, o_phase, o_valid, o_state};
         mask = '1;
         if (!exp[4+PHW]) mask[3 +: PHW] = '0;
         n_vec++;
         if ((act & mask) !== (exp & mask)) begin
            n_err++;
            $display("FAIL sb_cycle t=%0t: got %b expected %b", $time, act, exp);
         end
      end
   end

   task automatic measure_sam(input int bound, output int n, output int ph);
      n = -1; ph = -1;
      for (int c = 1; c <= bound && n < 0; c++) begin
         @(posedge clk); #1;
         if (o_sam) begin n = c; ph = int'(o_phase); end
      end
   endtask

   initial begin
      int fs, fy, fv, st, n, ph, s1, s2, y1, y2, acks, ack_off, sam_off, val_off;
      bit found;
      vecs[0] = '{8'd3,   5,   4,   17,   16};
      vecs[1] = '{8'd0,   2,   1,   5,    4};
      vecs[2] = '{8'd1,   3,   2,   9,    8};
      vecs[3] = '{8'd255, 257, 256, 1025, 1024};
      vecs[4] = '{8'd7,   9,   8,   33,   32};
      vecs[5] = '{8'd10,  12,  11,  45,   44};

      rst_n = 1'b1; run = 1'b0; resync = 1'b0; cfg_load = 1'b0; div_cfg = 8'd0;
      #1 rst_n = 1'b0;
      repeat (2) @(negedge clk);
      #1 check("reset_outputs", int'({o_cfg_ack, o_sam, o_sym, o_phase, o_valid, o_state}), 0);

      // defaults with run held high
      @(negedge clk); rst_n = 1'b1; run = 1'b1;
      fs = -1; fy = -1; fv = -1; st = -1;
      for (int c = 1; c <= 200 && fv < 0; c++) begin
         @(posedge clk); #1;
         if (o_sam && fs < 0) fs = c;
         if (o_sym && fy < 0) fy = c;
         if (o_valid) begin fv = c; st = int'(o_state); end
      end
      check("dflt_first_sam", fs, 9);
      check("dflt_first_sym", fy, 33);
      check("dflt_valid_rise", fv, 129);
      check("dflt_run_state", st, 2);

      // resync three cycles after a strobe
      found = 0;
      for (int c = 0; c < 20 && !found; c++) begin @(posedge clk); #1; found = o_sam; end
      check("rsy_wait_sam", int'(found), 1);
      repeat (3) @(negedge clk);
      resync = 1'b1;
      @(posedge clk); #1;
      check("rsy_valid", int'(o_valid), 0);
      check("rsy_state", int'(o_state), 1);
      @(negedge clk); resync = 1'b0;
      measure_sam(20, n, ph);
      check("rsy_next_sam", n, 8);
      check("rsy_phase", ph, 0);

      // run dropped on the edge a strobe is due
      repeat (8) @(negedge clk);
      run = 1'b0;
      @(posedge clk); #1;
      check("stop_sam_suppressed", int'(o_sam), 0);
      check("stop_state", int'(o_state), 0);
      @(negedge clk); run = 1'b1;
      measure_sam(20, n, ph);
      check("restart_first_sam", n, 9);
      check("restart_phase", ph, 0);

      // period change while running
      found = 0;
      for (int c = 0; c < 300 && !found; c++) begin @(posedge clk); #1; found = o_valid; end
      check("cfg_wait_valid", int'(found), 1);
      @(negedge clk); cfg_load = 1'b1; div_cfg = 8'd1;
      @(negedge clk); cfg_load = 1'b0;
      found = 0;
      for (int c = 0; c < 100 && !found; c++) begin @(posedge clk); #1; found = o_sym; end
      check("cfg_sym_seen", int'(found), 1);
      check("cfg_apply_valid", int'(o_valid), 0);
      check("cfg_apply_state", int'(o_state), 1);
      check("cfg_apply_ack", int'(o_cfg_ack), 0);
      ack_off = -1; sam_off = -1; val_off = -1;
      for (int off = 1; off <= 60 && val_off < 0; off++) begin
         @(posedge clk); #1;
         if (o_cfg_ack && ack_off < 0) ack_off = off;
         if (o_sam && sam_off < 0) sam_off = off;
         if (o_valid) val_off = off;
      end
      check("cfg_ack_delay", ack_off, 1);
      check("cfg_new_period", sam_off, 2);
      check("cfg_reprime", val_off, 32);

      // table of divider settings loaded in IDLE
      for (int i = 0; i < 6; i++) begin
         @(negedge clk); run = 1'b0;
         @(negedge clk); cfg_load = 1'b1; div_cfg = vecs[i].div_cfg;
         @(posedge clk); #1;
         check("idle_cfg_ack", int'(o_cfg_ack), 1);
         @(negedge clk); cfg_load = 1'b0; run = 1'b1;
         s1 = -1; s2 = -1; y1 = -1; y2 = -1;
         for (int c = 1; c <= 3000 && y2 < 0; c++) begin
            @(posedge clk); #1;
            if (o_sam) begin if (s1 < 0) s1 = c; else if (s2 < 0) s2 = c; end
            if (o_sym) begin if (y1 < 0) y1 = c; else if (y2 < 0) y2 = c; end
         end
         check("tbl_first_sam", s1, vecs[i].exp_first);
         check("tbl_sam_gap", s2 - s1, vecs[i].exp_gap);
         check("tbl_first_sym", y1, vecs[i].exp_sym_first);
         check("tbl_sym_gap", y2 - y1, vecs[i].exp_sym_gap);
      end

      // reset while priming with a period change pending
      @(negedge clk); cfg_load = 1'b1; div_cfg = 8'd3;
      @(negedge clk); cfg_load = 1'b0;
      @(negedge clk); #2 rst_n = 1'b0;
      #1 check("midreset_outputs", int'({o_cfg_ack, o_sam, o_sym, o_phase, o_valid, o_state}), 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1; run = 1'b1;
      n = -1; acks = 0;
      for (int c = 1; c <= 40; c++) begin
         @(posedge clk); #1;
         if (o_cfg_ack) acks++;
         if (o_sam && n < 0) n = c;
      end
      check("postreset_first_sam", n, 9);
      check("postreset_no_ack", acks, 0);

      // randomized traffic, checked by the scoreboard
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         run      = ($urandom_range(0, 99) < 98);
         resync   = ($urandom_range(0, 99) < 1);
         cfg_load = ($urandom_range(0, 99) < 2);
         div_cfg  = 8'($urandom_range(0, 5));
         if ($urandom_range(0, 999) == 0) begin
            #2 rst_n = 1'b0;
            @(negedge clk); rst_n = 1'b1;
         end
      end
      @(negedge clk); run = 1'b0; resync = 1'b0; cfg_load = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
